// File: rtl/lynx_memctl.sv
// Lynx memory controller: bank/ctrl port decode, read-source mux, video plane writes, SDRAM handshake FSM.
// Optional macro LYNX_MEMCTL_TMO_EN adds the SDRAM ack timeout and the sticky err flag.
module lynx_memctl #(
   parameter int RAMAW  = 14,
   parameter int ROMAW  = 14,
   parameter int PLANES = 2,
   parameter int TMO    = 15
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  mreq,
   input  logic                  iorq,
   input  logic                  wr,
   input  logic                  rd,
   input  logic [15:0]           a,
   input  logic [7:0]            q,
   output logic [7:0]            d,
   output logic                  waitn,
   output logic [ROMAW-1:0]      romA,
   input  logic [7:0]            romDo,
   output logic                  sdrReq,
   output logic                  sdrWe,
   output logic [23:0]           sdrA,
   output logic [7:0]            sdrDi,
   input  logic [7:0]            sdrDo,
   input  logic                  sdrAck,
   output logic [PLANES-1:0]     vWe,
   output logic [13:0]           vA,
   output logic [7:0]            vDi,
   input  logic [PLANES*8-1:0]   vDo,
   output logic [7:0]            bank,
   output logic [4:0]            ctrl,
   output logic                  err,
   output logic [1:0]            fsmState
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAITACK = 2'd2, HOLD = 2'd3} state_t;

   state_t     stateNow;
   state_t     stateNext;
   logic [5:1] ctrlReg;
   logic       rdLast;
   logic       wrLast;
   logic [7:0] rdBuf;
   logic       tmoHit;
   logic       start;
   logic [7:0] planeD;
   logic       planeHit;

   // An access starts only on a strobe edge seen at a ce sample point.
   assign start = ce && !mreq &&
                  ((!wr && wrLast && !bank[0]) || (!rd && rdLast && !bank[5]));

   always_ff @(posedge clock) begin
      if (reset) stateNow <= IDLE;
      else       stateNow <= stateNext;
   end

   always_comb begin
      stateNext = stateNow;
      case (stateNow)
         IDLE:    if (start) stateNext = REQ;
         REQ:     stateNext = WAITACK;
         WAITACK: if (sdrAck || tmoHit) stateNext = HOLD;
         HOLD:    if (mreq) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_comb begin
      sdrReq   = (stateNow == REQ);
      waitn    = !((stateNow == REQ) || (stateNow == WAITACK));
      fsmState = stateNow;
   end

   // Edge trackers reset low so a strobe still held after reset cannot start an access.
   always_ff @(posedge clock) begin
      if (reset) begin
         bank    <= 8'h00;
         ctrlReg <= 5'h00;
         rdLast  <= 1'b0;
         wrLast  <= 1'b0;
         rdBuf   <= 8'hFF;
         sdrWe   <= 1'b0;
         sdrDi   <= 8'h00;
         vWe     <= '0;
      end else begin
         vWe <= '0;
         if (ce) begin
            rdLast <= rd;
            wrLast <= wr;
            if (!iorq && !wr) begin
               if (a[6:0] == 7'h7F) bank <= q;
               if (a[7] && !a[6] && !a[2] && !a[1]) ctrlReg <= q[5:1];
            end
            if (!mreq && !wr && wrLast && ctrlReg[5]) vWe <= bank[PLANES:1];
         end
         if (stateNow == IDLE && start) begin
            sdrWe <= ~wr;
            sdrDi <= q;
         end
         if (stateNow == WAITACK) begin
            if (sdrAck)      rdBuf <= sdrDo;
            else if (tmoHit) rdBuf <= 8'hFF;
         end
      end
   end

`ifdef LYNX_MEMCTL_TMO_EN
   logic [5:0] tmoCnt;

   assign tmoHit = (stateNow == WAITACK) && (tmoCnt == 6'(TMO - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         tmoCnt <= 6'd0;
         err    <= 1'b0;
      end else begin
         if (stateNow != WAITACK) tmoCnt <= 6'd0;
         else if (!tmoHit)        tmoCnt <= tmoCnt + 6'd1;
         if (tmoHit && !sdrAck) err <= 1'b1;
      end
   end
`else
   assign tmoHit = 1'b0;
   assign err    = 1'b0;
`endif

   generate
      if (RAMAW == 16) begin : g_ram96
         assign sdrA = {8'h00, a};
      end else begin : g_ram48
         assign sdrA = {10'h000, a[14], a[12:0]};
      end
   endgenerate

   assign romA = a[ROMAW-1:0];
   assign vA   = {a[14], a[12:0]};
   assign vDi  = q;
   assign ctrl = ctrlReg;

   // Walk planes high to low so the lowest unmasked plane wins.
   always_comb begin
      planeD   = 8'hFF;
      planeHit = 1'b0;
      for (int p = PLANES - 1; p >= 0; p--) begin
         if (!ctrlReg[2+p]) begin
            planeD   = vDo[p*8 +: 8];
            planeHit = 1'b1;
         end
      end
   end

   always_comb begin
      d = 8'hFF;
      if (!iorq) begin
         if (!rd && a[7:0] == 8'h80) d = {7'h7F, ~ctrlReg[1]};
      end else if (!bank[4] && a[15:14] == 2'b00) begin
         d = romDo;
      end else if (!bank[4] && a[15:13] == 3'b010) begin
         d = (ROMAW == 15) ? romDo : 8'hFF;
      end else if (!bank[5]) begin
         d = rdBuf;
      end else if (bank[6] && planeHit) begin
         d = planeD;
      end
   end

endmodule

// File: tb/tb_lynx_memctl.sv
// Directed bench for lynx_memctl (PLANES=3, TMO=15); timeout expectations follow LYNX_MEMCTL_TMO_EN.
module tb_lynx_memctl;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ce = 1'b1;
   logic        mreq = 1'b1;
   logic        iorq = 1'b1;
   logic        wr = 1'b1;
   logic        rd = 1'b1;
   logic [15:0] a = 16'h0000;
   logic [7:0]  q = 8'h00;
   logic [7:0]  romDo = 8'h00;
   logic [7:0]  sdrDo = 8'h00;
   logic        sdrAck = 1'b0;
   logic [23:0] vDo = 24'h332211;

   logic [7:0]  d;
   logic        waitn;
   logic [13:0] romA;
   logic        sdrReq;
   logic        sdrWe;
   logic [23:0] sdrA;
   logic [7:0]  sdrDi;
   logic [2:0]  vWe;
   logic [13:0] vA;
   logic [7:0]  vDi;
   logic [7:0]  bank;
   logic [4:0]  ctrl;
   logic        err;
   logic [1:0]  fsmState;

   int checks = 0;
   int errors = 0;

   int          reqCount, waitLow, vweCount, reqAt;
   logic        holdSeen;
   logic [23:0] capA;
   logic        capWe;
   logic [7:0]  capDi, capVdi;
   logic [2:0]  capVwe;
   logic [13:0] capVa;

   lynx_memctl #(.RAMAW(14), .ROMAW(14), .PLANES(3), .TMO(15)) dut (
      .clock(clock), .reset(reset), .ce(ce), .mreq(mreq), .iorq(iorq), .wr(wr), .rd(rd),
      .a(a), .q(q), .d(d), .waitn(waitn), .romA(romA), .romDo(romDo),
      .sdrReq(sdrReq), .sdrWe(sdrWe), .sdrA(sdrA), .sdrDi(sdrDi), .sdrDo(sdrDo), .sdrAck(sdrAck),
      .vWe(vWe), .vA(vA), .vDi(vDi), .vDo(vDo),
      .bank(bank), .ctrl(ctrl), .err(err), .fsmState(fsmState)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench did not finish");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic io_write(input logic [15:0] addr, input logic [7:0] data);
      a = addr;
      q = data;
      iorq = 1'b0;
      wr = 1'b0;
      tick();
      iorq = 1'b1;
      wr = 1'b1;
      tick();
   endtask

   // Clocks an access already strobed by the caller; drives ack ackDelay samples after sdrReq.
   task automatic run_access(input int ackDelay, input logic [7:0] ackData, input int maxCycles);
      reqCount = 0;
      waitLow  = 0;
      vweCount = 0;
      reqAt    = -1;
      holdSeen = 1'b0;
      for (int cyc = 0; cyc < maxCycles && !holdSeen; cyc++) begin
         tick();
         sdrAck = 1'b0;
         if (sdrReq) begin
            reqCount++;
            reqAt = cyc;
            capA  = sdrA;
            capWe = sdrWe;
            capDi = sdrDi;
         end
         if (vWe != 3'b000) begin
            vweCount++;
            capVwe = vWe;
            capVa  = vA;
            capVdi = vDi;
         end
         if (!waitn) waitLow++;
         if (fsmState == 2'd3) holdSeen = 1'b1;
         else if (reqAt >= 0 && cyc - reqAt == ackDelay) begin
            sdrAck = 1'b1;
            sdrDo  = ackData;
         end
      end
   endtask

   initial begin
      tick();
      tick();
      check("rst_bank", bank, 8'h00);
      check("rst_ctrl", ctrl, 5'h00);
      check("rst_err", err, 1'b0);
      check("rst_fsm", fsmState, 2'd0);
      check("rst_sdrreq", sdrReq, 1'b0);
      check("rst_waitn", waitn, 1'b1);
      check("rst_vwe", vWe, 3'b000);
      a = 16'h8000;
      #1;
      check("rst_rdbuf", d, 8'hFF);
      reset = 1'b0;
      tick();

      // ROM read with SDRAM disabled by bank[5]
      io_write(16'h007F, 8'h20);
      check("bank_20", bank, 8'h20);
      romDo = 8'hC3;
      a = 16'h0000;
      mreq = 1'b0;
      rd = 1'b0;
      reqCount = 0;
      repeat (4) begin
         tick();
         if (sdrReq) reqCount++;
      end
      check("rom_d", d, 8'hC3);
      check("rom_noreq", reqCount, 0);
      check("rom_waitn", waitn, 1'b1);
      a = 16'h2ABC;
      #1;
      check("rom_romA", romA, 14'h2ABC);
      check("rom_d_hi", d, 8'hC3);
      a = 16'h4000;
      #1;
      check("rom_ext_ff", d, 8'hFF);
      a = 16'h8000;
      #1;
      check("no_source_ff", d, 8'hFF);
      mreq = 1'b1;
      rd = 1'b1;
      tick();

      // Port 80 readback and decode
      a = 16'h0080;
      iorq = 1'b0;
      rd = 1'b0;
      #1;
      check("p80_bit0_1", d, 8'hFF);
      iorq = 1'b1;
      rd = 1'b1;
      tick();
      io_write(16'h0080, 8'h02);
      check("ctrl_01", ctrl, 5'h01);
      a = 16'h0080;
      iorq = 1'b0;
      rd = 1'b0;
      #1;
      check("p80_bit0_0", d, 8'hFE);
      iorq = 1'b1;
      rd = 1'b1;
      tick();
      io_write(16'h0084, 8'h20);
      check("ctrl_a2_ignored", ctrl, 5'h01);
      io_write(16'h0080, 8'h00);

      // SDRAM read, ack three clocks after the request
      io_write(16'h007F, 8'h00);
      a = 16'h8123;
      mreq = 1'b0;
      rd = 1'b0;
      run_access(3, 8'h5A, 20);
      check("rd_reqcount", reqCount, 1);
      check("rd_sdra", capA, 24'h000123);
      check("rd_sdrwe", capWe, 1'b0);
      check("rd_waitlow", waitLow, 4);
      check("rd_hold", holdSeen, 1'b1);
      check("rd_d", d, 8'h5A);
      mreq = 1'b1;
      rd = 1'b1;
      tick();
      check("rd_idle", fsmState, 2'd0);
      sdrDo = 8'h11;
      sdrAck = 1'b1;
      tick();
      sdrAck = 1'b0;
      tick();
      check("idle_ack_fsm", fsmState, 2'd0);
      check("idle_ack_buf", d, 8'h5A);

      // Multi-plane write; a[14] maps to vA[13]
      io_write(16'h007F, 8'h0E);
      io_write(16'h0080, 8'h20);
      check("ctrl_10", ctrl, 5'h10);
      a = 16'h4010;
      q = 8'h99;
      mreq = 1'b0;
      wr = 1'b0;
      run_access(1, 8'h00, 20);
      check("vwe_count", vweCount, 1);
      check("vwe_val", capVwe, 3'b111);
      check("vwe_va", capVa, 14'h2010);
      check("vwe_vdi", capVdi, 8'h99);
      check("wr_sdrwe", capWe, 1'b1);
      check("wr_sdrdi", capDi, 8'h99);
      check("wr_sdra", capA, 24'h002010);
      mreq = 1'b1;
      wr = 1'b1;
      tick();

      // Plane read priority
      io_write(16'h007F, 8'h60);
      a = 16'h8000;
      mreq = 1'b0;
      rd = 1'b0;
      #1;
      check("plane0_read", d, 8'h11);
      mreq = 1'b1;
      rd = 1'b1;
      tick();
      io_write(16'h0080, 8'h24);
      a = 16'h8000;
      mreq = 1'b0;
      rd = 1'b0;
      #1;
      check("plane1_read", d, 8'h22);
      mreq = 1'b1;
      rd = 1'b1;
      tick();
      io_write(16'h0080, 8'h3C);
      a = 16'h8000;
      mreq = 1'b0;
      rd = 1'b0;
      #1;
      check("planes_masked", d, 8'hFF);
      mreq = 1'b1;
      rd = 1'b1;
      tick();

      // Ack never arrives (timeout build) or arrives very late (no-timeout build)
      io_write(16'h007F, 8'h00);
      io_write(16'h0080, 8'h00);
      a = 16'h8123;
      mreq = 1'b0;
      rd = 1'b0;
`ifdef LYNX_MEMCTL_TMO_EN
      run_access(-1, 8'h00, 40);
      check("tmo_waitlow", waitLow, 16);
      check("tmo_hold", holdSeen, 1'b1);
      check("tmo_d", d, 8'hFF);
      check("tmo_err", err, 1'b1);
`else
      run_access(30, 8'h77, 40);
      check("notmo_waitlow", waitLow, 31);
      check("notmo_hold", holdSeen, 1'b1);
      check("notmo_d", d, 8'h77);
      check("notmo_err", err, 1'b0);
`endif
      mreq = 1'b1;
      rd = 1'b1;
      tick();

      // Reset during WAITACK, then a late ack
      a = 16'h8123;
      mreq = 1'b0;
      rd = 1'b0;
      tick();
      tick();
      tick();
      check("pre_rst_waitack", fsmState, 2'd2);
      reset = 1'b1;
      mreq = 1'b1;
      rd = 1'b1;
      tick();
      reset = 1'b0;
      sdrDo = 8'h66;
      sdrAck = 1'b1;
      reqCount = 0;
      tick();
      if (sdrReq) reqCount++;
      sdrAck = 1'b0;
      repeat (3) begin
         tick();
         if (sdrReq) reqCount++;
      end
      check("rst_mid_fsm", fsmState, 2'd0);
      check("rst_mid_waitn", waitn, 1'b1);
      check("rst_mid_noreq", reqCount, 0);
      check("rst_mid_buf", d, 8'hFF);
      check("rst_mid_err", err, 1'b0);
      check("rst_mid_bank", bank, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
